// File: rtl/usb_types_pkg.sv
// Line-state type shared by the USB transmit and receive paths.
// Encoding is {dp, dm} as seen on the full-speed differential pair.
package usb_types_pkg;

  typedef enum logic [1:0] {
    D_SE0 = 2'b00,
    D_K   = 2'b01,
    D_J   = 2'b10
  } d_port_t;

endpackage

// File: rtl/usb_tx.sv
// USB low/full speed transmitter.
// Takes bytes from the SIE over valid/ready and sends them after SYNC.
// Bits go out LSB first, with bit stuffing and NRZI coding, then EOP.
// Every line register moves only on clk_en, one pulse per bit time.
// Each clk_en sends the bit picked by the current state and picks the next.
// This means txd trails the state register by one bit time.
module usb_tx
  import usb_types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output d_port_t    txd,
  output logic       oe,
  output logic       active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    EOP0  = 3'd4,
    EOP1  = 3'd5,
    EOP2  = 3'd6
  } state_t;

  // SYNC is seven 0s then a 1, LSB first.
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  state_t     state_reg, state_next;
  logic [7:0] shift_reg;
  logic [3:0] bit_cnt_reg;   // bits of the current byte sent so far, 0..8
  logic [2:0] ones_reg;      // run of consecutive 1s on the wire, 0..6
  d_port_t    level_reg;     // NRZI line level of the last bit sent

  logic       serial_bit;
  logic [3:0] cnt_inc;
  logic [2:0] ones_next;
  logic       stuff_now;
  logic       boundary;
  logic       load;
  d_port_t    level_next;
  d_port_t    txd_next;
  logic       oe_next;

  // State register: advances once per bit time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  // Next state: stuffing decision and byte-boundary handoff.
  always_comb begin
    state_next = state_reg;
    serial_bit = 1'b0;
    cnt_inc    = bit_cnt_reg + 4'd1;
    ones_next  = ones_reg;
    stuff_now  = 1'b0;
    boundary   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid) begin
          state_next = SYNC;
        end
      end
      SYNC, DATA: begin
        serial_bit = shift_reg[0];
        ones_next  = serial_bit ? ones_reg + 3'd1 : 3'd0;
        stuff_now  = (ones_next == 3'd6);
        // If a stuff bit is due, the boundary waits until after it.
        boundary   = !stuff_now && (cnt_inc == 4'd8);
        if (stuff_now) begin
          state_next = STUFF;
        end else if (boundary) begin
          state_next = valid ? DATA : EOP0;
        end
      end
      STUFF: begin
        ones_next = 3'd0;
        boundary  = (bit_cnt_reg == 4'd8);
        if (boundary) begin
          state_next = valid ? DATA : EOP0;
        end else begin
          state_next = DATA;
        end
      end
      EOP0:    state_next = EOP1;
      EOP1:    state_next = EOP2;
      EOP2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load = boundary && valid;

  // Output decode: the NRZI level and line symbol for the bit sent now.
  always_comb begin
    level_next = level_reg;
    txd_next   = D_J;
    oe_next    = 1'b1;
    case (state_reg)
      IDLE: begin
        oe_next    = 1'b0;
        level_next = D_J;
      end
      SYNC, DATA: begin
        if (!serial_bit) begin
          level_next = (level_reg == D_J) ? D_K : D_J;
        end
        txd_next = level_next;
      end
      STUFF: begin
        level_next = (level_reg == D_J) ? D_K : D_J;
        txd_next   = level_next;
      end
      EOP0, EOP1: txd_next = D_SE0;
      EOP2: begin
        txd_next   = D_J;
        level_next = D_J;
      end
      default: oe_next = 1'b0;
    endcase
  end

  // Datapath and line outputs. ready is the only register updated off clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= 8'h00;
      bit_cnt_reg <= 4'd0;
      ones_reg    <= 3'd0;
      level_reg   <= D_J;
      txd         <= D_J;
      oe          <= 1'b0;
      active      <= 1'b0;
      ready       <= 1'b0;
    end else begin
      ready <= load & clk_en;
      if (clk_en) begin
        txd       <= txd_next;
        oe        <= oe_next;
        active    <= oe_next;
        level_reg <= level_next;
        ones_reg  <= ones_next;
        case (state_reg)
          IDLE: begin
            if (valid) begin
              shift_reg   <= SYNC_BYTE;
              bit_cnt_reg <= 4'd0;
              ones_reg    <= 3'd0;
            end
          end
          SYNC, DATA: begin
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_cnt_reg <= cnt_inc;
          end
          default: ;
        endcase
        if (load) begin
          shift_reg   <= data;
          bit_cnt_reg <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Randomised scoreboard bench for usb_tx.
// Each packet request pushes the expected line symbols into a queue.
// The expected symbols come from SYNC/data bits, stuffing by run length, and NRZI.
// A separate monitor pops one symbol per bit time while oe is high.
module tb_usb_tx;
  import usb_types_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  d_port_t    txd;
  logic       oe;
  logic       active;

  usb_tx dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .txd    (txd),
    .oe     (oe),
    .active (active)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  int      div = 2;
  int      en_cnt = 0;
  int      ready_total = 0;
  bit      mon_on = 1'b0;
  logic    en_d = 1'b0;
  logic    rst_d = 1'b1;
  logic    ready_d = 1'b0;
  d_port_t txd_prev = D_J;
  logic    oe_prev = 1'b0;
  d_port_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic d_port_t flip(input d_port_t l);
    return (l == D_J) ? D_K : D_J;
  endfunction

  // Reference: bit list -> stuffing by run length -> NRZI -> EOP symbols.
  task automatic push_expected(input byte_q_t bytes);
    logic    bitq[$];
    d_port_t level;
    int      run;
    for (int i = 0; i < 8; i++) bitq.push_back(i == 7);
    foreach (bytes[b]) begin
      for (int i = 0; i < 8; i++) bitq.push_back(bytes[b][i]);
    end
    level = D_J;
    run   = 0;
    foreach (bitq[k]) begin
      if (!bitq[k]) begin
        level = flip(level);
        run   = 0;
      end else begin
        run++;
      end
      exp_q.push_back(level);
      if (run == 6) begin
        level = flip(level);
        exp_q.push_back(level);
        run = 0;
      end
    end
    exp_q.push_back(D_SE0);
    exp_q.push_back(D_SE0);
    exp_q.push_back(D_J);
  endtask

  // clk_en cadence: one pulse every div clocks.
  always @(negedge clk) begin
    en_cnt++;
    if (en_cnt >= div) en_cnt = 0;
    clk_en = (en_cnt == 0);
  end

  always @(posedge clk) begin
    en_d  <= clk_en;
    rst_d <= reset;
  end

  // Monitor: pops one expected symbol per bit time while oe is high.
  always @(negedge clk) begin
    d_port_t e;
    if (mon_on && !rst_d) begin
      if (ready) begin
        ready_total++;
        check("ready_width", ready_d, 1'b0);
      end
      if (en_d) begin
        if (oe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_oe", oe, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("txd", txd, e);
          end
          check("active_hi", active, 1'b1);
        end else begin
          check("idle_txd", txd, D_J);
          check("idle_active", active, 1'b0);
        end
      end else begin
        check("txd_hold", txd, txd_prev);
        check("oe_hold", oe, oe_prev);
      end
    end
    txd_prev = txd;
    oe_prev  = oe;
    ready_d  = ready;
  end

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_oe(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (oe === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_packet(input byte_q_t bytes, input string tag);
    int snap;
    int nsym;
    int limit;
    bit ok;
    limit = div * 40;
    push_expected(bytes);
    nsym = exp_q.size();
    snap = ready_total;
    valid = 1'b1;
    data  = (bytes.size() > 0) ? bytes[0] : 8'($urandom);
    if (bytes.size() == 0) begin
      wait_oe(1'b1, limit, ok);
      if (!ok) fail("zero_len_start");
      valid = 1'b0;
    end else begin
      for (int i = 0; i < bytes.size(); i++) begin
        wait_ready(limit, ok);
        if (!ok) begin
          fail("ready_wait");
          break;
        end
        if (i + 1 < bytes.size()) data = bytes[i + 1];
        else valid = 1'b0;
      end
      valid = 1'b0;
    end
    wait_oe(1'b0, limit * 2, ok);
    if (!ok) fail("oe_fall");
    repeat (div * 2) @(negedge clk);
    check("exp_drained", exp_q.size(), 0);
    check("ready_count", ready_total - snap, bytes.size());
    $display("PKT %s div=%0d bytes=%0d symbols=%0d readys=%0d", tag, div, bytes.size(), nsym,
             ready_total - snap);
    exp_q.delete();
  endtask

  initial begin
    byte_q_t pk;
    bit      ok;
    bit      saw_oe;
    int      snap;

    repeat (4) @(negedge clk);
    check("rst_txd", txd, D_J);
    check("rst_oe", oe, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_ready", ready, 1'b0);
    reset  = 1'b0;
    mon_on = 1'b1;
    repeat (4) @(negedge clk);

    div = 2;
    pk = {8'h00};       send_packet(pk, "byte_00");
    pk = {8'hFF};       send_packet(pk, "byte_FF");
    pk = {8'h3F};       send_packet(pk, "byte_3F");
    pk = {8'hF0, 8'h0F}; send_packet(pk, "F0_0F");
    pk = {};            send_packet(pk, "zero_len");
    div = 16;
    pk = {8'hFE};       send_packet(pk, "FE_lowspeed");

    // Reset while the second data byte is on the wire.
    div = 2;
    pk = {8'($urandom), 8'hFF, 8'($urandom)};
    push_expected(pk);
    valid = 1'b1;
    data  = pk[0];
    wait_ready(div * 40, ok);
    if (!ok) fail("rst_ready1");
    data = pk[1];
    wait_ready(div * 40, ok);
    if (!ok) fail("rst_ready2");
    data = pk[2];
    repeat (div * 3) @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    snap  = ready_total;
    @(negedge clk);
    check("midrst_txd", txd, D_J);
    check("midrst_oe", oe, 1'b0);
    check("midrst_active", active, 1'b0);
    check("midrst_ready", ready, 1'b0);
    exp_q.delete();
    reset = 1'b0;
    saw_oe = 1'b0;
    repeat (div * 30) begin
      @(negedge clk);
      if (oe) saw_oe = 1'b1;
    end
    check("midrst_quiet_oe", saw_oe, 1'b0);
    check("midrst_no_ready", ready_total - snap, 0);
    $display("PKT reset_mid_packet div=%0d readys_after=%0d", div, ready_total - snap);
    pk = {8'h5A, 8'h00}; send_packet(pk, "after_reset");

    for (int n = 0; n < 14; n++) begin
      div = $urandom_range(1, 4);
      pk  = {};
      for (int b = 0; b < $urandom_range(0, 4); b++) begin
        pk.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      end
      send_packet(pk, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
